rv_decode_stage: RTL and testbench



---
 rtl/rv_decode_stage.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_rv_decode_stage.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_decode_stage.sv
// rtl/rv_decode_stage.sv - RV32I (+optional M) decode stage with two-entry skid buffer
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   flush             : drop every held instruction and the one offered this cycle
//   in_valid/in_ready : fetch-side handshake; in_inst, in_pc carry the instruction
//   out_valid/out_ready : execute-side handshake
//   out_pc, instr_type, illegal, imm, rs1/rs2/rd, rs1e/rs2e/rde,
//   mem_size, mem_unsigned : registered decoded fields of the head instruction
module rv_decode_stage #(
  parameter int XLEN      = 32,
  parameter int REG_WIDTH = 5,
  parameter bit ENABLE_M  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_inst,
  input  logic [XLEN-1:0]      in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [5:0]           instr_type,
  output logic                 illegal,
  output logic [XLEN-1:0]      imm,
  output logic [REG_WIDTH-1:0] rs1,
  output logic [REG_WIDTH-1:0] rs2,
  output logic [REG_WIDTH-1:0] rd,
  output logic                 rs1e,
  output logic                 rs2e,
  output logic                 rde,
  output logic [1:0]           mem_size,
  output logic                 mem_unsigned
);

  localparam logic [5:0] CODE_ILLEGAL = 6'd63;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  // Instruction format: selects the immediate layout and the field-use bits.
  typedef enum logic [2:0] {
    FMT_N, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
  } fmt_t;

  typedef enum logic [1:0] {
    EMPTY, ONE, FULL
  } state_t;

  // Both buffer slots hold fully decoded instructions.
  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [5:0]           itype;
    logic                 illegal;
    logic [XLEN-1:0]      imm;
    logic [REG_WIDTH-1:0] rs1;
    logic [REG_WIDTH-1:0] rs2;
    logic [REG_WIDTH-1:0] rd;
    logic                 rs1e;
    logic                 rs2e;
    logic                 rde;
    logic [1:0]           mem_size;
    logic                 mem_unsigned;
  } dec_t;

  dec_t   in_dec;
  dec_t   out_q;
  dec_t   skid_q;
  state_t state;
  logic   out_valid_q;
  logic   in_ready_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [5:0]  itype;
  fmt_t        fmt;
  logic [31:0] imm32;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];

  // Opcode/funct classification. itype stays CODE_ILLEGAL unless a legal
  // encoding is recognised; fmt is only meaningful for legal encodings.
  always_comb begin
    itype = CODE_ILLEGAL;
    fmt   = FMT_N;
    case (opcode)
      OPC_LUI: begin
        itype = 6'd6;
        fmt   = FMT_U;
      end
      OPC_AUIPC: begin
        itype = 6'd7;
        fmt   = FMT_U;
      end
      OPC_JAL: begin
        itype = 6'd8;
        fmt   = FMT_J;
      end
      OPC_JALR: begin
        fmt = FMT_I;
        if (funct3 == 3'd0) itype = 6'd9;
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        // funct3 0,1 -> 10,11 and 4..7 -> 12..15; 2 and 3 are undefined.
        if (funct3 == 3'd0 || funct3 == 3'd1) itype = 6'd10 + {3'b000, funct3};
        else if (funct3[2])                   itype = 6'd8 + {3'b000, funct3};
      end
      OPC_OPIMM: begin
        fmt = FMT_I;
        case (funct3)
          3'd0: itype = 6'd16;
          3'd2: itype = 6'd17;
          3'd3: itype = 6'd18;
          3'd4: itype = 6'd19;
          3'd6: itype = 6'd20;
          3'd7: itype = 6'd21;
          3'd1: if (funct7 == F7_BASE) itype = 6'd22;
          3'd5: begin
            if (funct7 == F7_BASE)     itype = 6'd23;
            else if (funct7 == F7_ALT) itype = 6'd24;
          end
          default: itype = CODE_ILLEGAL;
        endcase
      end
      OPC_OP: begin
        fmt = FMT_R;
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'd0: itype = 6'd25;
            3'd1: itype = 6'd27;
            3'd2: itype = 6'd28;
            3'd3: itype = 6'd29;
            3'd4: itype = 6'd30;
            3'd5: itype = 6'd31;
            3'd6: itype = 6'd33;
            3'd7: itype = 6'd34;
            default: itype = CODE_ILLEGAL;
          endcase
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'd0)      itype = 6'd26;
          else if (funct3 == 3'd5) itype = 6'd32;
        end else if (funct7 == F7_MUL && ENABLE_M) begin
          itype = 6'd40 + {3'b000, funct3};
        end
      end
      OPC_LOAD: begin
        fmt = FMT_I;
        if (funct3 != 3'd3 && funct3 != 3'd6 && funct3 != 3'd7) itype = 6'd35;
      end
      OPC_STORE: begin
        fmt = FMT_S;
        if (funct3 < 3'd3) itype = 6'd36;
      end
      OPC_FENCE: begin
        if (funct3 == 3'd0) itype = 6'd37;
      end
      OPC_SYSTEM: begin
        if (in_inst == 32'h0000_0073)      itype = 6'd38;
        else if (in_inst == 32'h0010_0073) itype = 6'd39;
      end
      default: itype = CODE_ILLEGAL;
    endcase
    if (itype == CODE_ILLEGAL) fmt = FMT_N;
  end

  // 32-bit immediate; widened to XLEN below by replicating bit 31.
  always_comb begin
    imm32 = 32'd0;
    case (fmt)
      FMT_I: imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      FMT_S: imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      FMT_B: imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                      in_inst[30:25], in_inst[11:8], 1'b0};
      FMT_U: imm32 = {in_inst[31:12], 12'd0};
      FMT_J: imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                      in_inst[20], in_inst[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
  end

  always_comb begin
    in_dec              = '0;
    in_dec.pc           = in_pc;
    in_dec.itype        = itype;
    in_dec.illegal      = (itype == CODE_ILLEGAL);
    in_dec.imm          = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
    in_dec.rs1          = REG_WIDTH'(in_inst[19:15]);
    in_dec.rs2          = REG_WIDTH'(in_inst[24:20]);
    in_dec.rd           = REG_WIDTH'(in_inst[11:7]);
    in_dec.rs1e         = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
    in_dec.rs2e         = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
    in_dec.rde          = ((fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J))
                          && (in_inst[11:7] != 5'd0);
    in_dec.mem_size     = (itype == 6'd35 || itype == 6'd36) ? funct3[1:0] : 2'd0;
    in_dec.mem_unsigned = (itype == 6'd35) ? funct3[2] : 1'b0;
  end

  logic accept;
  logic consume;

  assign accept  = in_valid && in_ready_q;
  assign consume = out_valid_q && out_ready;

  // Buffer control. in_ready is a flop cleared exactly when SKID fills, so
  // out_ready never reaches in_ready combinationally; an accept can therefore
  // never coincide with a valid SKID.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_q       <= '0;
      skid_q      <= '0;
    end else if (flush) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            out_q       <= in_dec;
            out_valid_q <= 1'b1;
            state       <= ONE;
          end
        end
        ONE: begin
          if (consume && accept) begin
            out_q <= in_dec;
          end else if (consume) begin
            out_valid_q <= 1'b0;
            state       <= EMPTY;
          end else if (accept) begin
            skid_q     <= in_dec;
            in_ready_q <= 1'b0;
            state      <= FULL;
          end
        end
        FULL: begin
          if (consume) begin
            out_q      <= skid_q;
            in_ready_q <= 1'b1;
            state      <= ONE;
          end
        end
        default: begin
          state       <= EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_pc       = out_q.pc;
  assign instr_type   = out_q.itype;
  assign illegal      = out_q.illegal;
  assign imm          = out_q.imm;
  assign rs1          = out_q.rs1;
  assign rs2          = out_q.rs2;
  assign rd           = out_q.rd;
  assign rs1e         = out_q.rs1e;
  assign rs2e         = out_q.rs2e;
  assign rde          = out_q.rde;
  assign mem_size     = out_q.mem_size;
  assign mem_unsigned = out_q.mem_unsigned;

endmodule

// File: tb/tb_rv_decode_stage.sv
// tb/tb_rv_decode_stage.sv - bench for rv_decode_stage
module tb_rv_decode_stage;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int F_N = 0, F_R = 1, F_I = 2, F_S = 3, F_B = 4, F_U = 5, F_J = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, flush, in_valid, out_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;

  logic            in_ready, out_valid, illegal, rs1e, rs2e, rde, mem_unsigned;
  logic [XLEN-1:0] out_pc, imm;
  logic [5:0]      instr_type;
  logic [RW-1:0]   rs1, rs2, rd;
  logic [1:0]      mem_size;

  logic            nm_in_ready, nm_out_valid, nm_illegal, nm_rs1e, nm_rs2e, nm_rde, nm_mem_unsigned;
  logic [XLEN-1:0] nm_out_pc, nm_imm;
  logic [5:0]      nm_instr_type;
  logic [RW-1:0]   nm_rs1, nm_rs2, nm_rd;
  logic [1:0]      nm_mem_size;

  rv_decode_stage #(.XLEN(XLEN), .REG_WIDTH(RW), .ENABLE_M(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .instr_type(instr_type), .illegal(illegal), .imm(imm),
    .rs1(rs1), .rs2(rs2), .rd(rd), .rs1e(rs1e), .rs2e(rs2e), .rde(rde),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned)
  );

  rv_decode_stage #(.XLEN(XLEN), .REG_WIDTH(RW), .ENABLE_M(1'b0)) dut_nm (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(nm_in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(nm_out_valid), .out_ready(out_ready), .out_pc(nm_out_pc),
    .instr_type(nm_instr_type), .illegal(nm_illegal), .imm(nm_imm),
    .rs1(nm_rs1), .rs2(nm_rs2), .rd(nm_rd), .rs1e(nm_rs1e), .rs2e(nm_rs2e), .rde(nm_rde),
    .mem_size(nm_mem_size), .mem_unsigned(nm_mem_unsigned)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference decoder: a mask/match table in the style of the ISA opcode map.
  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    int          code;
    int          fmt;
  } pat_t;
  pat_t pats[$];

  task automatic add_pat(input logic [31:0] mask, input logic [31:0] match, input int code, input int fmt);
    pat_t p;
    p.mask = mask; p.match = match; p.code = code; p.fmt = fmt;
    pats.push_back(p);
  endtask

  task automatic build_pats();
    int bf[6];
    int of[6];
    logic [31:0] opm[10];
    int lf[5];
    bf  = '{0, 1, 4, 5, 6, 7};
    of  = '{0, 2, 3, 4, 6, 7};
    opm = '{32'h33, 32'h40000033, 32'h1033, 32'h2033, 32'h3033,
            32'h4033, 32'h5033, 32'h40005033, 32'h6033, 32'h7033};
    lf  = '{0, 1, 2, 4, 5};
    add_pat(32'h7F, 32'h37, 6, F_U);
    add_pat(32'h7F, 32'h17, 7, F_U);
    add_pat(32'h7F, 32'h6F, 8, F_J);
    add_pat(32'h707F, 32'h67, 9, F_I);
    for (int i = 0; i < 6; i++) add_pat(32'h707F, 32'h63 | (bf[i] << 12), 10 + i, F_B);
    for (int i = 0; i < 6; i++) add_pat(32'h707F, 32'h13 | (of[i] << 12), 16 + i, F_I);
    add_pat(32'hFE00707F, 32'h1013, 22, F_I);
    add_pat(32'hFE00707F, 32'h5013, 23, F_I);
    add_pat(32'hFE00707F, 32'h40005013, 24, F_I);
    for (int i = 0; i < 10; i++) add_pat(32'hFE00707F, opm[i], 25 + i, F_R);
    for (int i = 0; i < 8; i++) add_pat(32'hFE00707F, 32'h02000033 | (i << 12), 40 + i, F_R);
    for (int i = 0; i < 5; i++) add_pat(32'h707F, 32'h03 | (lf[i] << 12), 35, F_I);
    for (int i = 0; i < 3; i++) add_pat(32'h707F, 32'h23 | (i << 12), 36, F_S);
    add_pat(32'h707F, 32'h0F, 37, F_N);
    add_pat(32'hFFFFFFFF, 32'h73, 38, F_N);
    add_pat(32'hFFFFFFFF, 32'h00100073, 39, F_N);
  endtask

  task automatic model_decode(input logic [31:0] inst, input bit en_m,
                              output int code, output bit ill, output logic [31:0] mimm,
                              output logic [2:0] en, output logic [2:0] mem);
    int fmt;
    int s;
    code = 63;
    fmt  = F_N;
    foreach (pats[k]) begin
      if (((inst & pats[k].mask) == pats[k].match) && (en_m || pats[k].code < 40)) begin
        code = pats[k].code;
        fmt  = pats[k].fmt;
      end
    end
    ill = (code == 63);
    s = $signed(inst) >>> 20;
    case (fmt)
      F_I: mimm = s;
      F_S: mimm = ((s >>> 5) <<< 5) | int'((inst >> 7) & 31);
      F_B: mimm = (inst[31] ? -4096 : 0) + int'(inst[7]) * 2048
                  + int'((inst >> 25) & 63) * 32 + int'((inst >> 8) & 15) * 2;
      F_U: mimm = inst & 32'hFFFFF000;
      F_J: mimm = (inst[31] ? -1048576 : 0) + int'((inst >> 12) & 255) * 4096
                  + int'((inst >> 20) & 1) * 2048 + int'((inst >> 21) & 1023) * 2;
      default: mimm = 0;
    endcase
    case (fmt)
      F_R: en = 3'b111;
      F_I: en = 3'b101;
      F_S, F_B: en = 3'b110;
      F_U, F_J: en = 3'b001;
      default: en = 3'b000;
    endcase
    if (inst[11:7] == 5'd0) en[0] = 1'b0;
    mem = 3'b000;
    if (code == 35) mem = {inst[13:12], inst[14]};
    if (code == 36) mem = {inst[13:12], 1'b0};
  endtask

  task automatic check_dec(input string tag, input logic [31:0] inst, input logic [31:0] pc);
    int code; bit ill; logic [31:0] mimm; logic [2:0] en; logic [2:0] mem;
    model_decode(inst, 1'b1, code, ill, mimm, en, mem);
    chk({tag, "_type"}, instr_type, code);
    chk({tag, "_illegal"}, illegal, ill);
    chk({tag, "_imm"}, imm, mimm);
    chk({tag, "_pc"}, out_pc, pc);
    chk({tag, "_regs"}, {rs1, rs2, rd}, {inst[19:15], inst[24:20], inst[11:7]});
    chk({tag, "_en"}, {rs1e, rs2e, rde}, en);
    chk({tag, "_mem"}, {mem_size, mem_unsigned}, mem);
    model_decode(inst, 1'b0, code, ill, mimm, en, mem);
    chk({tag, "_nm_type"}, nm_instr_type, code);
    chk({tag, "_nm_illegal"}, nm_illegal, ill);
    chk({tag, "_nm_imm"}, nm_imm, mimm);
    chk({tag, "_nm_en"}, {nm_rs1e, nm_rs2e, nm_rde}, en);
    chk({tag, "_nm_misc"}, {nm_out_pc, nm_mem_size, nm_mem_unsigned, nm_rs1, nm_rs2, nm_rd},
        {pc, mem, inst[19:15], inst[24:20], inst[11:7]});
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_type"}, instr_type, 6'd0);
    chk({tag, "_illegal"}, illegal, 1'b0);
    chk({tag, "_imm"}, imm, 32'd0);
    chk({tag, "_pc"}, out_pc, 32'd0);
    chk({tag, "_fields"}, {rs1, rs2, rd, rs1e, rs2e, rde, mem_size, mem_unsigned}, 64'd0);
  endtask

  function automatic logic [31:0] gen_inst();
    int k;
    if ($urandom_range(0, 3) == 0) return $urandom;
    k = $urandom_range(0, pats.size() - 1);
    return ($urandom & ~pats[k].mask) | pats[k].match;
  endfunction

  typedef struct {
    logic [31:0] inst;
    logic [5:0]  typ;
    logic [31:0] imm;
    logic [2:0]  en;
    logic        ill;
    logic [2:0]  mem;
  } vec_t;
  vec_t vecs[16];

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;
  ent_t q[$];

  initial begin
    ent_t e;
    bit do_pop, do_push;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = 32'd0; in_pc = '0;
    build_pats();

    vecs[0]  = '{32'hFFF00093, 6'd16, 32'hFFFFFFFF, 3'b101, 1'b0, 3'b000};
    vecs[1]  = '{32'hFE208EE3, 6'd10, 32'hFFFFFFFC, 3'b110, 1'b0, 3'b000};
    vecs[2]  = '{32'h022081B3, 6'd40, 32'h00000000, 3'b111, 1'b0, 3'b000};
    vecs[3]  = '{32'h00000000, 6'd63, 32'h00000000, 3'b000, 1'b1, 3'b000};
    vecs[4]  = '{32'h00000033, 6'd25, 32'h00000000, 3'b110, 1'b0, 3'b000};
    vecs[5]  = '{32'h00014083, 6'd35, 32'h00000000, 3'b101, 1'b0, 3'b001};
    vecs[6]  = '{32'h0020A423, 6'd36, 32'h00000008, 3'b110, 1'b0, 3'b100};
    vecs[7]  = '{32'h00000073, 6'd38, 32'h00000000, 3'b000, 1'b0, 3'b000};
    vecs[8]  = '{32'h00100073, 6'd39, 32'h00000000, 3'b000, 1'b0, 3'b000};
    vecs[9]  = '{32'h000000F3, 6'd63, 32'h00000000, 3'b000, 1'b1, 3'b000};
    vecs[10] = '{32'h123452B7, 6'd6,  32'h12345000, 3'b001, 1'b0, 3'b000};
    vecs[11] = '{32'hFF9FF0EF, 6'd8,  32'hFFFFFFF8, 3'b001, 1'b0, 3'b000};
    vecs[12] = '{32'h0FF0000F, 6'd37, 32'h00000000, 3'b000, 1'b0, 3'b000};
    vecs[13] = '{32'h00009067, 6'd63, 32'h00000000, 3'b000, 1'b1, 3'b000};
    vecs[14] = '{32'h4030D093, 6'd24, 32'h00000403, 3'b101, 1'b0, 3'b000};
    vecs[15] = '{32'h00000001, 6'd63, 32'h00000000, 3'b000, 1'b1, 3'b000};

    step(); step();
    check_zero("reset");
    reset = 1'b0;

    // Directed vectors streamed back-to-back at full throughput.
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_inst  = vecs[i].inst;
      in_pc    = 32'h100 + 32'(4 * i);
      step();
      chk($sformatf("vec%0d_out_valid", i), out_valid, 1'b1);
      chk($sformatf("vec%0d_type", i), instr_type, vecs[i].typ);
      chk($sformatf("vec%0d_imm", i), imm, vecs[i].imm);
      chk($sformatf("vec%0d_en", i), {rs1e, rs2e, rde}, vecs[i].en);
      chk($sformatf("vec%0d_illegal", i), illegal, vecs[i].ill);
      chk($sformatf("vec%0d_mem", i), {mem_size, mem_unsigned}, vecs[i].mem);
      check_dec($sformatf("vec%0d", i), vecs[i].inst, 32'h100 + 32'(4 * i));
    end
    chk("mul_nm_type", nm_instr_type, 6'd63);
    in_valid = 1'b0;
    step();
    chk("drain_out_valid", out_valid, 1'b0);

    // Stall: A and B accepted, C held until the buffer drains.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst = 32'h00100093; in_pc = 32'h200;
    step();
    chk("stall_a_valid", out_valid, 1'b1);
    chk("stall_a_pc", out_pc, 32'h200);
    chk("stall_a_in_ready", in_ready, 1'b1);
    in_inst = 32'h00200113; in_pc = 32'h204;
    step();
    chk("stall_b_in_ready", in_ready, 1'b0);
    chk("stall_b_pc", out_pc, 32'h200);
    in_inst = 32'h00300193; in_pc = 32'h208;
    step();
    chk("stall_c_in_ready", in_ready, 1'b0);
    chk("stall_c_pc_hold", out_pc, 32'h200);
    chk("stall_c_rd_hold", rd, 5'd1);
    out_ready = 1'b1;
    step();
    chk("release_b_pc", out_pc, 32'h204);
    chk("release_b_rd", rd, 5'd2);
    chk("release_in_ready", in_ready, 1'b1);
    step();
    chk("release_c_pc", out_pc, 32'h208);
    chk("release_c_valid", out_valid, 1'b1);
    in_valid = 1'b0;
    step();
    chk("release_empty", out_valid, 1'b0);

    // Flush from FULL while a new instruction is offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst = 32'h00100093; in_pc = 32'h300; step();
    in_inst = 32'h00200113; in_pc = 32'h304; step();
    chk("flush_full", in_ready, 1'b0);
    in_inst = 32'h00400213; in_pc = 32'h308; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    step(); step();
    chk("flush_no_ghost", out_valid, 1'b0);

    // Random traffic against a two-deep FIFO model.
    for (int i = 0; i < 2000; i++) begin
      chk("rnd_out_valid", out_valid, q.size() > 0);
      chk("rnd_in_ready", in_ready, q.size() < 2);
      chk("rnd_nm_hs", {nm_out_valid, nm_in_ready}, {q.size() > 0, q.size() < 2});
      if (q.size() > 0) check_dec("rnd", q[0].inst, q[0].pc);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_inst   = gen_inst();
      in_pc     = $urandom & 32'hFFFFFFFC;
      do_pop    = (q.size() > 0) && out_ready;
      do_push   = in_valid && (q.size() < 2) && !flush;
      e.inst = in_inst; e.pc = in_pc;
      step();
      if (flush) q.delete();
      else begin
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(e);
      end
    end

    // Reset mid-stream, colliding with flush and an offered instruction.
    flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    step();
    in_valid = 1'b1;
    in_inst = 32'hFFF00093; in_pc = 32'h400; step();
    in_inst = 32'h022081B3; in_pc = 32'h404; step();
    reset = 1'b1; flush = 1'b1; in_inst = 32'h00500293; in_pc = 32'h408;
    step();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    check_zero("midreset");
    out_ready = 1'b1;
    step();
    chk("midreset_no_ghost", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
